instr_issue_seq: RTL and testbench
==================================

Name: instr_issue_seq

Overview:
- Instruction-issue sequencer: the initiator side of the processor's instruction/done handshake.
- Holds a small loadable program store and presents one 32-bit instruction at a time to the processor.
- Advances to the next instruction only after the processor signals completion, and reports when the program has been fully issued.
- Replaces bench-driven instruction feeding in system-level integration.

Parameters:
- DEPTH, 8, number of program words.
- AW, 3, address width; DEPTH = 2**AW.
- DW, 32, instruction width.
- TIMEOUT, 64, cycles to wait for done before a timeout fault (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load_en  input  1  write load_data into the program store at load_addr.
- load_addr  input  AW  program store write address.
- load_data  input  DW  program word to write.
- prog_len  input  AW+1  number of words to issue; sampled at start.
- start  input  1  begin issuing from address 0.
- done  input  1  processor completion level/pulse.
- instruction  output  DW  current instruction to the processor.
- instr_valid  output  1  instruction is valid and awaiting completion.
- pc  output  AW  address of the current instruction.
- issued_count  output  AW+1  instructions completed in this run.
- busy  output  1  high in RUN.
- finished  output  1  program fully issued; held until the next start.
- fault  output  1  timeout fault (optional feature only; otherwise tied 0).

Behaviour:
- Reset (async, rst_n=0) values:
  - State IDLE.
  - instruction=0, instr_valid=0, pc=0, issued_count=0, busy=0, finished=0, fault=0, done_q=0.
  - Program store contents are not reset.
- Done detection:
  - done is registered into done_q each cycle.
  - done_rise = done & ~done_q.
  - Only rising edges count; a done held high counts once.
- Load:
  - load_en writes the store on the clock edge.
  - Accepted only in IDLE or FINISH; ignored in RUN.
- Length latch:
  - At start, len_q = min(prog_len, DEPTH).
- IDLE / FINISH on start=1:
  - If len_q=0: go to FINISH (finished=1, issued_count=0).
  - Otherwise go to RUN: pc=0, instruction=mem[0], instr_valid=1, busy=1, finished=0, issued_count=0, fault=0.
  - The instruction is visible the cycle after start (1-cycle latency).
- RUN on done_rise:
  - issued_count += 1.
  - If pc == len_q-1: go to FINISH; instr_valid=0, busy=0, finished=1. instruction keeps its last value.
  - Otherwise pc += 1 and instruction = mem[pc+1] on the same edge. instr_valid stays 1.
- Instruction stability: instruction is stable for the whole wait; it changes only on the edge following a done_rise.
- Start in RUN: ignored.
- done_rise while in IDLE or FINISH: ignored; no count.
- Simultaneous start and load_en in IDLE: the load takes effect first; start reads the updated mem[0] on the next cycle via the RUN fetch.
  - Implementation: the RUN entry registers instruction from the store after the write.
  - Equivalent rule: mem[0] read in the start cycle bypasses load_data if load_addr==0.
- Counter widths: pc never wraps past len_q-1. issued_count saturates at DEPTH (cannot exceed it by construction).
- Reset mid-RUN: immediate return to the reset values; no partial count is retained.

Optional Feature:
- Macro: INSTR_ISSUE_TIMEOUT_EN.
- With the macro defined:
  - A watchdog counter clears on RUN entry and on every done_rise, and increments each RUN cycle.
  - On reaching TIMEOUT-1 without a done_rise: go to FINISH with fault=1, finished=1, instr_valid=0, busy=0. issued_count holds its current value.
  - fault clears on the next start or on reset.
- Without the macro: no watchdog logic; fault is tied 0; RUN waits indefinitely for done.

Test Plan:
- Load words 0..7 = 32'h20043456, 32'h2005FFFF, 32'h00A43014, 32'h20030007, 32'h00663004, 32'h00031842, 32'h5C859ABC, 32'h08123456; prog_len=8; start; one done pulse 3 cycles after each new instruction -> instructions appear in order with pc 0..7; finished=1 after the 8th pulse; issued_count=8; instr_valid=0.
- prog_len=3, same program -> only the first three words are issued; finished after 3 done pulses; pc=2; issued_count=3.
- done held high for 10 cycles during RUN -> exactly one advance (pc 0->1); issued_count=1.
- load_en during RUN targeting address 1 with 32'hDEADBEEF -> ignored; word 1 is still 32'h2005FFFF when issued.
- rst_n asserted low mid-run at pc=4 -> all outputs return to 0 asynchronously; a subsequent start restarts at pc=0 with issued_count=0.
- With INSTR_ISSUE_TIMEOUT_EN defined and TIMEOUT=16: start, no done -> fault=1 and finished=1 at cycle 16 after RUN entry; issued_count=0. Without the macro, the same stimulus leaves busy=1 indefinitely and fault=0.

Source files
------------

// File: rtl/instr_issue_seq.sv
// rtl/instr_issue_seq.sv - instruction-issue sequencer with loadable program store
// Optional done-timeout watchdog enabled by defining INSTR_ISSUE_TIMEOUT_EN.
module instr_issue_seq #(
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int DW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [DW-1:0] load_data,
   input  logic [AW:0]   prog_len,
   input  logic          start,
   input  logic          done,
   output logic [DW-1:0] instruction,
   output logic          instr_valid,
   output logic [AW-1:0] pc,
   output logic [AW:0]   issued_count,
   output logic          busy,
   output logic          finished,
   output logic          fault
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);

   if (DEPTH != (1 << AW) || TIMEOUT < 2) begin : g_param_check
      $error("instr_issue_seq: DEPTH must equal 2**AW and TIMEOUT must be at least 2");
   end

   logic [DW-1:0] mem [DEPTH];

   state_t        state_q, state_d;
   logic [DW-1:0] instruction_q, instruction_d;
   logic          instr_valid_q, instr_valid_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW:0]   issued_q, issued_d;
   logic [AW:0]   len_q, len_d;
   logic          busy_q, busy_d;
   logic          finished_q, finished_d;
   logic          done_q;

   logic          done_rise;
   logic          load_ok;
   logic          last_word;
   logic [AW:0]   start_len;
   logic [DW-1:0] first_word;

`ifdef INSTR_ISSUE_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
   logic [WW-1:0] wd_q, wd_d;
   logic          fault_q, fault_d;
`endif

   assign done_rise  = done & ~done_q;
   assign load_ok    = load_en && (state_q != RUN);
   assign last_word  = ({1'b0, pc_q} == (len_q - 1'b1));
   assign start_len  = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
   // A load to word 0 in the start cycle must be seen by the first fetch.
   assign first_word = (load_ok && load_addr == '0) ? load_data : mem[0];

   always_comb begin
      state_d       = state_q;
      instruction_d = instruction_q;
      instr_valid_d = instr_valid_q;
      pc_d          = pc_q;
      issued_d      = issued_q;
      len_d         = len_q;
      busy_d        = busy_q;
      finished_d    = finished_q;
`ifdef INSTR_ISSUE_TIMEOUT_EN
      wd_d          = wd_q;
      fault_d       = fault_q;
`endif
      case (state_q)
         IDLE, FINISH: begin
            if (start) begin
               len_d    = start_len;
               pc_d     = '0;
               issued_d = '0;
`ifdef INSTR_ISSUE_TIMEOUT_EN
               wd_d     = '0;
               fault_d  = 1'b0;
`endif
               if (start_len == '0) begin
                  state_d       = FINISH;
                  instr_valid_d = 1'b0;
                  busy_d        = 1'b0;
                  finished_d    = 1'b1;
               end else begin
                  state_d       = RUN;
                  instruction_d = first_word;
                  instr_valid_d = 1'b1;
                  busy_d        = 1'b1;
                  finished_d    = 1'b0;
               end
            end
         end
         RUN: begin
            if (done_rise) begin
               issued_d = issued_q + 1'b1;
`ifdef INSTR_ISSUE_TIMEOUT_EN
               wd_d     = '0;
`endif
               if (last_word) begin
                  state_d       = FINISH;
                  instr_valid_d = 1'b0;
                  busy_d        = 1'b0;
                  finished_d    = 1'b1;
               end else begin
                  pc_d          = pc_q + 1'b1;
                  instruction_d = mem[pc_q + 1'b1];
               end
            end
`ifdef INSTR_ISSUE_TIMEOUT_EN
            else if (wd_q == WD_LAST) begin
               state_d       = FINISH;
               instr_valid_d = 1'b0;
               busy_d        = 1'b0;
               finished_d    = 1'b1;
               fault_d       = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         instruction_q <= '0;
         instr_valid_q <= 1'b0;
         pc_q          <= '0;
         issued_q      <= '0;
         len_q         <= '0;
         busy_q        <= 1'b0;
         finished_q    <= 1'b0;
         done_q        <= 1'b0;
`ifdef INSTR_ISSUE_TIMEOUT_EN
         wd_q          <= '0;
         fault_q       <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         instruction_q <= instruction_d;
         instr_valid_q <= instr_valid_d;
         pc_q          <= pc_d;
         issued_q      <= issued_d;
         len_q         <= len_d;
         busy_q        <= busy_d;
         finished_q    <= finished_d;
         done_q        <= done;
`ifdef INSTR_ISSUE_TIMEOUT_EN
         wd_q          <= wd_d;
         fault_q       <= fault_d;
`endif
      end
   end

   // Program store is deliberately not reset.
   always_ff @(posedge clk) begin
      if (load_ok) mem[load_addr] <= load_data;
   end

   assign instruction  = instruction_q;
   assign instr_valid  = instr_valid_q;
   assign pc           = pc_q;
   assign issued_count = issued_q;
   assign busy         = busy_q;
   assign finished     = finished_q;
`ifdef INSTR_ISSUE_TIMEOUT_EN
   assign fault        = fault_q;
`else
   assign fault        = 1'b0;
`endif

endmodule

// File: tb/tb_instr_issue_seq.sv
// tb/tb_instr_issue_seq.sv - scoreboard bench for instr_issue_seq
// Covers the INSTR_ISSUE_TIMEOUT_EN build as well when the macro is defined.
module tb_instr_issue_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_en;
   logic [2:0]  load_addr;
   logic [31:0] load_data;
   logic [3:0]  prog_len;
   logic        start;
   logic        done;
   logic [31:0] instruction;
   logic        instr_valid;
   logic [2:0]  pc;
   logic [3:0]  issued_count;
   logic        busy;
   logic        finished;
   logic        fault;

   instr_issue_seq #(.DEPTH(8), .AW(3), .DW(32), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .prog_len(prog_len), .start(start), .done(done),
      .instruction(instruction), .instr_valid(instr_valid), .pc(pc),
      .issued_count(issued_count), .busy(busy), .finished(finished), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          fin;
      int          pc;
      logic [31:0] ins;
      int          cnt;
      bit          flt;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] exp_mem [8];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_issue(input int p);
      exp_t e;
      e.fin = 0; e.pc = p; e.ins = exp_mem[p]; e.cnt = p; e.flt = 0;
      sb.push_back(e);
   endtask

   task automatic push_finish(input int p, input int c, input bit f);
      exp_t e;
      e.fin = 1; e.pc = p; e.ins = '0; e.cnt = c; e.flt = f;
      sb.push_back(e);
   endtask

   task automatic do_start(input int len);
      prog_len = 4'(len);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse();
      repeat (3) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
   endtask

   task automatic wait_finished();
      int k = 0;
      while (!finished && k < 20) begin
         tick();
         k++;
      end
      check("finish_wait", {31'b0, finished}, 32'd1);
   endtask

   task automatic run_len(input int plen, input int n);
      for (int i = 0; i < n; i++) push_issue(i);
      push_finish(n - 1, n, 0);
      do_start(plen);
      for (int i = 0; i < n; i++) pulse();
      wait_finished();
   endtask

   // Monitor: each newly presented instruction or finish event pops one entry.
   bit pv = 0, pf = 0;
   int ppc = 0;
   always @(negedge clk) begin
      exp_t e;
      if (instr_valid && (!pv || int'(pc) != ppc)) begin
         if (sb.size() == 0) check("issue_unexpected", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            check("issue_kind", {31'b0, e.fin}, 32'd0);
            check("issue_pc", {29'b0, pc}, e.pc);
            check("issue_instr", instruction, e.ins);
            check("issue_count", {28'b0, issued_count}, e.cnt);
         end
      end
      if (finished && !pf) begin
         if (sb.size() == 0) check("finish_unexpected", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            check("finish_kind", {31'b0, e.fin}, 32'd1);
            check("finish_pc", {29'b0, pc}, e.pc);
            check("finish_count", {28'b0, issued_count}, e.cnt);
            check("finish_valid", {31'b0, instr_valid}, 32'd0);
            check("finish_busy", {31'b0, busy}, 32'd0);
            check("finish_fault", {31'b0, fault}, {31'b0, e.flt});
         end
      end
      pv  = instr_valid;
      pf  = finished;
      ppc = int'(pc);
   end

   initial begin
      exp_mem[0] = 32'h20043456; exp_mem[1] = 32'h2005FFFF;
      exp_mem[2] = 32'h00A43014; exp_mem[3] = 32'h20030007;
      exp_mem[4] = 32'h00663004; exp_mem[5] = 32'h00031842;
      exp_mem[6] = 32'h5C859ABC; exp_mem[7] = 32'h08123456;
      rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      prog_len = '0; start = 1'b0; done = 1'b0;
      #2;
      check("rst_instr", instruction, 32'd0);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_pc", {29'b0, pc}, 32'd0);
      check("rst_count", {28'b0, issued_count}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_finished", {31'b0, finished}, 32'd0);
      check("rst_fault", {31'b0, fault}, 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         load_en = 1'b1; load_addr = 3'(i); load_data = exp_mem[i];
         tick();
      end
      load_en = 1'b0;

      // Zero length finishes immediately.
      push_finish(0, 0, 0);
      do_start(0);
      tick();
      check("len0_busy", {31'b0, busy}, 32'd0);

      // Start and load to word 0 in the same cycle.
      exp_mem[0] = 32'h11112222;
      push_issue(0);
      push_finish(0, 1, 0);
      load_en = 1'b1; load_addr = 3'd0; load_data = 32'h11112222;
      do_start(1);
      load_en = 1'b0;
      pulse();
      wait_finished();
      exp_mem[0] = 32'h20043456;
      load_en = 1'b1; load_addr = 3'd0; load_data = exp_mem[0];
      tick();
      load_en = 1'b0;

      run_len(8, 8);
      run_len(3, 3);
      run_len(15, 8);

      // Load during RUN is ignored.
      push_issue(0); push_issue(1); push_finish(1, 2, 0);
      do_start(2);
      load_en = 1'b1; load_addr = 3'd1; load_data = 32'hDEADBEEF;
      tick();
      load_en = 1'b0;
      repeat (2) pulse();
      wait_finished();

      // Held done advances once, then reset mid-run at pc 4.
      for (int i = 0; i < 5; i++) push_issue(i);
      do_start(8);
      done = 1'b1;
      repeat (10) tick();
      done = 1'b0;
      tick();
      check("held_pc", {29'b0, pc}, 32'd1);
      check("held_count", {28'b0, issued_count}, 32'd1);
      repeat (3) pulse();
      check("pre_rst_pc", {29'b0, pc}, 32'd4);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_instr", instruction, 32'd0);
      check("midrst_valid", {31'b0, instr_valid}, 32'd0);
      check("midrst_pc", {29'b0, pc}, 32'd0);
      check("midrst_count", {28'b0, issued_count}, 32'd0);
      check("midrst_busy", {31'b0, busy}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      run_len(2, 2);

      // No done at all: watchdog build faults, default build waits forever.
      push_issue(0);
`ifdef INSTR_ISSUE_TIMEOUT_EN
      push_finish(0, 0, 1);
`endif
      do_start(8);
      repeat (15) tick();
      check("to_early_fault", {31'b0, fault}, 32'd0);
      check("to_early_busy", {31'b0, busy}, 32'd1);
      tick();
`ifdef INSTR_ISSUE_TIMEOUT_EN
      check("to_fault", {31'b0, fault}, 32'd1);
      check("to_finished", {31'b0, finished}, 32'd1);
      check("to_count", {28'b0, issued_count}, 32'd0);
`else
      repeat (40) tick();
      check("nto_busy", {31'b0, busy}, 32'd1);
      check("nto_fault", {31'b0, fault}, 32'd0);
`endif
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      check("sb_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
